// File: rtl/rnn_pkg.sv
// Shared constants, RNNoise 5 ms band tables and FSM state type for the band-gain path.
// Edge table is in bins; reciprocal table holds round(65536/size) per band.
package rnn_pkg;

    localparam int float     = 32;
    localparam int NB_BANDS  = 22;
    localparam int FREQ_SIZE = 481;
    localparam int GW        = 16;
    localparam int Q15_ONE   = 32768;

    localparam logic [8:0] BAND_EDGE [NB_BANDS] = '{
        9'd0,   9'd4,   9'd8,   9'd12,  9'd16,  9'd20,  9'd24,  9'd28,
        9'd32,  9'd40,  9'd48,  9'd56,  9'd64,  9'd80,  9'd96,  9'd112,
        9'd136, 9'd160, 9'd192, 9'd240, 9'd312, 9'd400
    };

    // Band 21 has no upper neighbour, so its reciprocal is never used.
    localparam logic [15:0] BAND_RECIP [NB_BANDS] = '{
        16'd16384, 16'd16384, 16'd16384, 16'd16384,
        16'd16384, 16'd16384, 16'd16384, 16'd16384,
        16'd8192,  16'd8192,  16'd8192,  16'd8192,
        16'd4096,  16'd4096,  16'd4096,
        16'd2731,  16'd2731,
        16'd2048,  16'd1365,  16'd910,   16'd745,
        16'd0
    };

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        STREAM
    } state_t;

endpackage

// File: rtl/band_gain_interp_if.sv
// Frame-in / bin-out handshake bundle for band_gain_interp.
// slave is the block's view; master is the producer/consumer side.
interface band_gain_interp_if;
    import rnn_pkg::*;

    logic [NB_BANDS*float-1:0] gains;
    logic                      gains_valid;
    logic                      gains_ready;
    logic [GW-1:0]             bin_gain;
    logic [8:0]                bin_idx;
    logic                      bin_last;
    logic                      bin_valid;
    logic                      bin_ready;

    modport master (
        output gains, gains_valid, bin_ready,
        input  gains_ready, bin_gain, bin_idx, bin_last, bin_valid
    );

    modport slave (
        input  gains, gains_valid, bin_ready,
        output gains_ready, bin_gain, bin_idx, bin_last, bin_valid
    );

endinterface

// File: rtl/f32_to_q15.sv
// Combinational float32 -> unsigned Q1.15 gain; negatives/denormals -> 0, >=1.0/inf/NaN -> 1.0.
// Finite values below 1.0 are truncated toward zero.
module f32_to_q15
    import rnn_pkg::*;
(
    input  logic [float-1:0] i_f32,
    output logic [GW-1:0]    o_q15
);

    logic        w_sign;
    logic [7:0]  w_exp;
    logic [22:0] w_mant;

    assign w_sign = i_f32[31];
    assign w_exp  = i_f32[30:23];
    assign w_mant = i_f32[22:0];

    // value = {1,mant} * 2^(exp-135); below exp 111 every bit shifts out.
    always_comb begin
        o_q15 = '0;
        if (w_sign || w_exp == 8'd0) begin
            o_q15 = '0;
        end else if (w_exp >= 8'd127) begin
            o_q15 = GW'(Q15_ONE);
        end else if (w_exp < 8'd111) begin
            o_q15 = '0;
        end else begin
            o_q15 = GW'({1'b1, w_mant} >> (8'd135 - w_exp));
        end
    end

endmodule

// File: rtl/band_gain_interp.sv
// Converts 22 float band gains to Q1.15 and streams 481 linearly interpolated bin gains.
// First bin 22 cycles after frame acceptance, then one per cycle; output beat holds while bin_ready is low.
module band_gain_interp
    import rnn_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    band_gain_interp_if.slave bif,
    output logic              busy
);

    localparam logic [8:0] LAST_BIN   = 9'(FREQ_SIZE - 1);
    localparam logic [8:0] ZERO_START = BAND_EDGE[NB_BANDS-1];
    localparam logic [4:0] LAST_BAND  = 5'(NB_BANDS - 1);

    state_t                    r_state;
    logic [NB_BANDS*float-1:0] r_hold;
    logic [GW-1:0]             r_q [NB_BANDS];
    logic [4:0]                r_conv_idx;
    logic [8:0]                r_bin;
    logic [4:0]                r_band;
    logic [6:0]                r_k;
    logic                      r_bin_valid;
    logic                      r_bin_last;
    logic [GW-1:0]             r_bin_gain;
    logic [8:0]                r_bin_idx;

    logic [float-1:0]          w_word;
    logic [GW-1:0]             w_q15;
    logic [4:0]                w_band_nx;
    logic [GW-1:0]             w_qa;
    logic [GW-1:0]             w_qb;
    logic signed [16:0]        w_delta;
    logic signed [23:0]        w_delta_x;
    logic signed [23:0]        w_k_x;
    logic signed [23:0]        w_p;
    logic signed [40:0]        w_p_x;
    logic signed [40:0]        w_r_x;
    logic signed [40:0]        w_prod;
    logic signed [24:0]        w_t;
    logic signed [25:0]        w_sum;
    logic [GW-1:0]             w_gain;
    logic                      w_band_end;
    logic                      w_take;
    logic                      w_load;

    assign w_word = r_hold[{r_conv_idx, 5'd0} +: float];

    f32_to_q15 u_f32_to_q15 (
        .i_f32 (w_word),
        .o_q15 (w_q15)
    );

    // Counters always point at the next bin to load, so the product chain lands straight in the output register.
    assign w_band_nx = (r_band == LAST_BAND) ? LAST_BAND : r_band + 5'd1;
    assign w_qa      = r_q[r_band];
    assign w_qb      = r_q[w_band_nx];
    assign w_delta   = {1'b0, w_qb} - {1'b0, w_qa};
    assign w_delta_x = {{7{w_delta[16]}}, w_delta};
    assign w_k_x     = {17'd0, r_k};
    assign w_p       = w_delta_x * w_k_x;
    assign w_p_x     = {{17{w_p[23]}}, w_p};
    assign w_r_x     = {25'd0, BAND_RECIP[r_band]};
    assign w_prod    = w_p_x * w_r_x;
    assign w_t       = 25'(w_prod >>> 16);
    assign w_sum     = {10'd0, w_qa} + {w_t[24], w_t};

    always_comb begin
        w_gain = '0;
        if (r_bin >= ZERO_START || w_sum[25]) begin
            w_gain = '0;
        end else if (w_sum[24:0] > 25'(Q15_ONE)) begin
            w_gain = GW'(Q15_ONE);
        end else begin
            w_gain = w_sum[GW-1:0];
        end
    end

    assign w_band_end = ({2'b00, r_k} == BAND_EDGE[w_band_nx] - BAND_EDGE[r_band] - 9'd1);
    assign w_take     = r_bin_valid && bif.bin_ready;
    assign w_load     = (r_state == CONV && r_conv_idx == LAST_BAND) ||
                        (r_state == STREAM && w_take && !r_bin_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_hold      <= '0;
            for (int i = 0; i < NB_BANDS; i++) r_q[i] <= '0;
            r_conv_idx  <= '0;
            r_bin       <= '0;
            r_band      <= '0;
            r_k         <= '0;
            r_bin_valid <= 1'b0;
            r_bin_last  <= 1'b0;
            r_bin_gain  <= '0;
            r_bin_idx   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bif.gains_valid) begin
                        r_hold     <= bif.gains;
                        r_conv_idx <= '0;
                        r_state    <= CONV;
                    end
                end
                CONV: begin
                    r_q[r_conv_idx] <= w_q15;
                    if (r_conv_idx == LAST_BAND) begin
                        r_conv_idx <= '0;
                        r_state    <= STREAM;
                    end else begin
                        r_conv_idx <= r_conv_idx + 5'd1;
                    end
                end
                STREAM: begin
                    if (w_take && r_bin_last) begin
                        r_state     <= IDLE;
                        r_bin_valid <= 1'b0;
                        r_bin_last  <= 1'b0;
                        r_bin       <= '0;
                        r_band      <= '0;
                        r_k         <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase

            // Entry from CONV uses q[0]/q[1], which were written many cycles earlier.
            if (w_load) begin
                r_bin_valid <= 1'b1;
                r_bin_gain  <= w_gain;
                r_bin_idx   <= r_bin;
                r_bin_last  <= (r_bin == LAST_BIN);
                r_bin       <= r_bin + 9'd1;
                if (r_bin < ZERO_START) begin
                    if (w_band_end) begin
                        r_band <= r_band + 5'd1;
                        r_k    <= '0;
                    end else begin
                        r_k    <= r_k + 7'd1;
                    end
                end
            end
        end
    end

    assign bif.gains_ready = (r_state == IDLE);
    assign bif.bin_valid   = r_bin_valid;
    assign bif.bin_last    = r_bin_last;
    assign bif.bin_gain    = r_bin_gain;
    assign bif.bin_idx     = r_bin_idx;
    assign busy            = (r_state != IDLE);

endmodule

// File: tb/tb_band_gain_interp.sv
// Directed bench for band_gain_interp: hand-computed bin gains plus a small interpolation model.
module tb_band_gain_interp;
    import rnn_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;

    band_gain_interp_if bif ();

    band_gain_interp dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bif   (bif),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    int E [22] = '{0, 4, 8, 12, 16, 20, 24, 28, 32, 40, 48, 56, 64, 80, 96, 112,
                   136, 160, 192, 240, 312, 400};
    int R [21] = '{16384, 16384, 16384, 16384, 16384, 16384, 16384, 16384,
                   8192, 8192, 8192, 8192, 4096, 4096, 4096, 2731, 2731,
                   2048, 1365, 910, 745};

    logic [31:0] cw [7] = '{32'h3F000000, 32'hBF000000, 32'h7FC00000, 32'h3E800000,
                            32'h00400000, 32'h38000000, 32'h37800000};
    int          cq [7] = '{16384, 0, 32768, 8192, 0, 1, 0};

    logic [31:0] gw [22];
    int          mq [22];
    int          got_gain [481];
    int          c_beats, c_seq_err, c_last_err, c_stab_err;
    int          lat;
    logic        acc_busy, acc_rdy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_all(input logic [31:0] w, input int q);
        for (int i = 0; i < 22; i++) begin
            gw[i] = w;
            mq[i] = q;
        end
    endtask

    function automatic logic [22*32-1:0] pack();
        logic [22*32-1:0] f;
        for (int i = 0; i < 22; i++) f[i*32 +: 32] = gw[i];
        return f;
    endfunction

    function automatic int model_gain(input int b);
        int     i = 0;
        int     k, d, p, o;
        longint t;
        if (b >= 400) return 0;
        while (i < 20 && b >= E[i+1]) i++;
        k = b - E[i];
        d = mq[i+1] - mq[i];
        p = d * k;
        t = (longint'(p) * longint'(R[i])) >>> 16;
        o = mq[i] + int'(t);
        if (o < 0) o = 0;
        if (o > 32768) o = 32768;
        return o;
    endfunction

    // Called at a negedge while the DUT is idle; returns at the negedge showing the first beat.
    task automatic send_frame();
        bif.gains       = pack();
        bif.gains_valid = 1'b1;
        @(negedge clk);
        bif.gains_valid = 1'b0;
        acc_busy = busy;
        acc_rdy  = bif.gains_ready;
        lat = 0;
        while (!bif.bin_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic collect(input int stall_pct, input bit pulse, input int stop_at);
        int         cyc = 0;
        bit         pulsed = 1'b0;
        bit         prev_stall = 1'b0;
        bit         rdy;
        logic [15:0] p_gain = '0;
        logic [8:0]  p_idx = '0;
        logic        p_last = 1'b0;
        c_beats = 0; c_seq_err = 0; c_last_err = 0; c_stab_err = 0;
        while (c_beats < stop_at && cyc < 4000) begin
            if (prev_stall && (bif.bin_valid !== 1'b1 || bif.bin_gain !== p_gain ||
                               bif.bin_idx !== p_idx || bif.bin_last !== p_last))
                c_stab_err++;
            rdy = ($urandom_range(99) >= stall_pct);
            bif.bin_ready   = rdy;
            bif.gains_valid = 1'b0;
            if (pulse && !pulsed && c_beats == 100) begin
                bif.gains       = '0;
                bif.gains_valid = 1'b1;
                pulsed = 1'b1;
            end
            if (bif.bin_valid && rdy) begin
                if (bif.bin_idx !== 9'(c_beats)) c_seq_err++;
                if (bif.bin_last !== (c_beats == 480)) c_last_err++;
                got_gain[c_beats] = int'(bif.bin_gain);
                c_beats++;
            end
            prev_stall = bif.bin_valid && !rdy;
            p_gain = bif.bin_gain;
            p_idx  = bif.bin_idx;
            p_last = bif.bin_last;
            @(negedge clk);
            cyc++;
        end
        bif.bin_ready   = 1'b0;
        bif.gains_valid = 1'b0;
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_beats"}, c_beats, 481);
        chk({tag, "_seq"}, c_seq_err, 0);
        chk({tag, "_last"}, c_last_err, 0);
        chk({tag, "_stable"}, c_stab_err, 0);
        chk({tag, "_ready_after"}, bif.gains_ready, 1);
        chk({tag, "_busy_after"}, busy, 0);
    endtask

    task automatic check_model(input string tag);
        int bad = 0;
        for (int b = 0; b < 481; b++) if (got_gain[b] != model_gain(b)) bad++;
        chk(tag, bad, 0);
    endtask

    initial begin
        rst_n           = 1'b0;
        bif.gains       = '0;
        bif.gains_valid = 1'b0;
        bif.bin_ready   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_gains_ready", bif.gains_ready, 1);
        chk("rst_bin_valid", bif.bin_valid, 0);
        chk("rst_bin_last", bif.bin_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_bin_gain", bif.bin_gain, 0);
        chk("rst_bin_idx", bif.bin_idx, 0);

        // All bands at 1.0
        set_all(32'h3F800000, 32768);
        send_frame();
        chk("acc_busy", acc_busy, 1);
        chk("acc_gains_ready", acc_rdy, 0);
        chk("first_beat_latency", lat, 22);
        collect(0, 1'b0, 481);
        check_stream("unity");
        chk("unity_bin0", got_gain[0], 32768);
        chk("unity_bin399", got_gain[399], 32768);
        chk("unity_bin400", got_gain[400], 0);
        chk("unity_bin480", got_gain[480], 0);
        check_model("unity_model");

        // Ramp 0 -> 1.0 across band 0
        set_all(32'h3F800000, 32768);
        gw[0] = 32'h00000000; mq[0] = 0;
        send_frame();
        collect(0, 1'b0, 481);
        check_stream("ramp0");
        chk("ramp0_bin0", got_gain[0], 0);
        chk("ramp0_bin1", got_gain[1], 8192);
        chk("ramp0_bin2", got_gain[2], 16384);
        chk("ramp0_bin3", got_gain[3], 24576);
        chk("ramp0_bin4", got_gain[4], 32768);

        // Conversion corner cases on band 0 (bin 0 equals q[0])
        for (int j = 0; j < 7; j++) begin
            set_all(32'h3F800000, 32768);
            gw[0] = cw[j];
            send_frame();
            collect(0, 1'b0, 481);
            chk($sformatf("cvt_%08h_bin0", cw[j]), got_gain[0], cq[j]);
        end

        // Band 20 ramp with 30% stalls and a stray gains_valid mid-stream
        set_all(32'h3F800000, 32768);
        gw[20] = 32'h00000000; mq[20] = 0;
        send_frame();
        chk("b20_latency", lat, 22);
        collect(30, 1'b1, 481);
        check_stream("b20");
        chk("b20_bin312", got_gain[312], 0);
        chk("b20_bin356", got_gain[356], 16390);
        check_model("b20_model");
        repeat (4) @(negedge clk);
        chk("stray_frame_ignored_valid", bif.bin_valid, 0);
        chk("stray_frame_ignored_busy", busy, 0);

        // Reset during CONV
        set_all(32'h3F800000, 32768);
        bif.gains       = pack();
        bif.gains_valid = 1'b1;
        @(negedge clk);
        bif.gains_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("conv_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("conv_rst_busy", busy, 0);
        chk("conv_rst_gains_ready", bif.gains_ready, 1);
        chk("conv_rst_bin_valid", bif.bin_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("conv_rst_no_resume", bif.bin_valid, 0);

        // Reset mid-STREAM at bin 200
        send_frame();
        collect(0, 1'b0, 200);
        chk("mid_beats", c_beats, 200);
        chk("mid_bin_idx", bif.bin_idx, 200);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_bin_valid", bif.bin_valid, 0);
        chk("mid_rst_bin_idx", bif.bin_idx, 0);
        chk("mid_rst_bin_gain", bif.bin_gain, 0);
        chk("mid_rst_bin_last", bif.bin_last, 0);
        chk("mid_rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Mixed frame after reset: 0.5, 0.25, 0.75, 1.0 repeating
        for (int i = 0; i < 22; i++) begin
            case (i % 4)
                0: begin gw[i] = 32'h3F000000; mq[i] = 16384; end
                1: begin gw[i] = 32'h3E800000; mq[i] = 8192;  end
                2: begin gw[i] = 32'h3F400000; mq[i] = 24576; end
                default: begin gw[i] = 32'h3F800000; mq[i] = 32768; end
            endcase
        end
        send_frame();
        chk("post_rst_latency", lat, 22);
        collect(0, 1'b0, 481);
        check_stream("post_rst");
        chk("post_rst_bin0", got_gain[0], 16384);
        chk("post_rst_bin1", got_gain[1], 14336);
        chk("post_rst_bin2", got_gain[2], 12288);
        chk("post_rst_bin241_floor", got_gain[241], 32540);
        check_model("post_rst_model");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/band_gain_interp.md
# band_gain_interp

Converts the 22 float32 band gains from the denoise output dense stage (`dense3`) into per-bin Q1.15 gains. It linearly interpolates across the RNNoise 5 ms band edges and streams 481 bin gains, one per handshake. It sits between `dense3` (sigmoid output) and the spectral gain-apply stage.

## Interface
Parameters:
- `float`, 32, width of one IEEE-754 single word.
- `NB_BANDS`, 22, number of band gains per frame.
- `FREQ_SIZE`, 481, number of output bins per frame.
- `GW`, 16, output gain width (unsigned Q1.15, 1.0 = 32768).

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous active-low reset.
- `gains` in NB_BANDS*float: band g[i] at `[i*float +: float]`.
- `gains_valid` in 1: `gains` holds a new frame.
- `gains_ready` out 1: block accepts a frame; high only in IDLE.
- `bin_gain` out GW: interpolated gain for `bin_idx`.
- `bin_idx` out 9: bin number 0..480.
- `bin_last` out 1: high on the bin 480 beat.
- `bin_valid` out 1: output beat present.
- `bin_ready` in 1: downstream accepts the beat.
- `busy` out 1: high in CONV and STREAM.

## Operation
- States: IDLE → CONV → STREAM → IDLE.
- IDLE:
  - `gains_ready`=1.
  - A frame is accepted on `gains_valid && gains_ready`: all 22 words are latched into a holding register, conv_idx=0, then go to CONV.
- CONV, 22 cycles, one band per cycle:
  - q[conv_idx] = f32_to_q15(word); conv_idx increments; after index 21, go to STREAM with bin=0, band=0, k=0.
- f32_to_q15 rules:
  - sign=1, or exponent=0 (zero/denormal) → 0.
  - exponent ≥ 127 (≥1.0, inf, NaN) → 32768.
  - Otherwise ({1,mant} × 2^(exp−127+15−23)), truncated toward zero. Exponent < 111 yields 0.
- Band edges in bins: E = {0,4,8,12,16,20,24,28,32,40,48,56,64,80,96,112,136,160,192,240,312,400}.
- Band sizes in bins: s = E[i+1]−E[i].
- Reciprocal ROM: R(s) = round(65536/s): 4→16384, 8→8192, 16→4096, 24→2731, 32→2048, 48→1365, 72→910, 88→745.
- STREAM, bins 0..399 (band i, k = bin−E[i]):
  - delta = q[i+1]−q[i], signed 17 b.
  - p = delta·k, signed 24 b.
  - t = (p·R) >>> 16, arithmetic shift, floor.
  - out = q[i]+t, clamped to [0, 32768].
  - At k = s−1 → band+1, k=0.
- STREAM, bins 400..480: out = 0.
- Beat advances only on `bin_valid && bin_ready`. The beat with `bin_last`=1 returns the FSM to IDLE.
- `gains_valid` outside IDLE is ignored. No frame is queued.

## Timing
- Reset values: `gains_ready`=1 (IDLE); `bin_valid`, `bin_last`, `busy`=0; `bin_gain`, `bin_idx`=0. All internal counters are 0.
- Acceptance at edge T0 → `busy`=1 from T0.
- `bin_valid`=1 with bin 0 from edge T0+22, after 22 CONV cycles.
- With `bin_ready` held high, there is one bin per cycle. The last beat is at T0+22+480, and `gains_ready`=1 the following cycle.
- Back-to-back frames: minimum period is 504 cycles.
- `bin_gain`, `bin_idx`, `bin_last` are registered. They hold stable while `bin_valid && !bin_ready`, and `bin_valid` never drops without a handshake.
- `gains_ready` is a decode of state==IDLE and is combinational from the state register.
- `rst_n` low at any point: asynchronous return to reset values. The current frame is discarded and the partial stream is not resumed.

## Structure
- Package `rnn_pkg`:
  - `float`, `NB_BANDS`, `FREQ_SIZE`, and `Q15_ONE`=32768.
  - Band-edge table E.
  - Reciprocal table R, indexed by band.
  - State enum {IDLE, CONV, STREAM}.
- Sub-module `f32_to_q15`: combinational float32→Q1.15 converter, float in, GW out. It is reused by later stages (VAD thresholding).
- Top level contains:
  - FSM.
  - Counters: conv_idx (5 b), bin (9 b), band (5 b), k (7 b).
  - 22×16 q register file.
  - One 17×7 multiplier and one 24×17 multiplier, registered at the output.

## Test plan
- All gains 0x3F800000 (1.0) → bins 0..399 = 32768, bins 400..480 = 0, `bin_last` only at bin 480, first beat 22 cycles after acceptance.
- g[0]=0x00000000, g[1]=0x3F800000, rest 1.0 → bins 0..3 = 0, 8192, 16384, 24576; bin 4 = 32768.
- Conversion edges on g[0] (band 0 spans bins 0..3):
  - 0x3F000000 → 16384.
  - 0xBF000000 → 0.
  - 0x7FC00000 → 32768.
  - 0x3E800000 → 8192.
  - 0x00400000 → 0.
- Band 20 (s=88): g[20]=0, g[21]=1.0 → bin 312 = 0, bin 356 (k=44) = 16384 (32768·44·745>>16 = 16390, within ±8 of 16384). Compare exactly against a model using the R table.
- Random `bin_ready` deassertion (30%) → no dropped or duplicated beats, outputs stable while stalled, exactly 481 beats. `gains_valid` pulsed mid-stream is ignored.
- `rst_n` asserted in CONV and again mid-STREAM (bin 200) → outputs at reset values immediately. A new frame after release streams correctly from bin 0.
